// File: rtl/trace_capture_if.sv
// Sample stream, trigger configuration, blanking and display read port of the
// trace capture controller, grouped as one bundle between front end and draw stage.
interface trace_capture_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic [1:0]        trig_mode;
    logic              arm;
    logic              vblnk;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        state;
    logic              frame_ready;
    logic              triggered;

    modport master (
        output sample_valid, sample_data, trig_level, trig_slope, trig_mode,
        output arm, vblnk, rd_addr,
        input  rd_data, state, frame_ready, triggered
    );

    modport slave (
        input  sample_valid, sample_data, trig_level, trig_slope, trig_mode,
        input  arm, vblnk, rd_addr,
        output rd_data, state, frame_ready, triggered
    );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Trigger-and-capture controller: captures 2^ADDR_W samples after a trigger into
// the back bank of a double-buffered memory and swaps banks on the next vblank edge.
module trace_capture_ctrl #(
    parameter int DATA_W       = 12,
    parameter int ADDR_W       = 8,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst,
    trace_capture_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TIMEOUT - 1);
    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    state_t              r_state;
    logic                r_bank_sel;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [TO_W-1:0]     r_timeout;
    logic [DATA_W-1:0]   r_prev_sample;
    logic                r_prev_valid;
    logic                r_trig;
    logic                r_vblnk_q;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_frame_ready;
    logic                r_triggered;
    logic [DATA_W-1:0]   r_mem [0:2*DEPTH-1];

    state_t              w_state_next;
    logic                w_bank_sel_next;
    logic [ADDR_W-1:0]   w_wr_addr_next;
    logic [TO_W-1:0]     w_timeout_next;
    logic [DATA_W-1:0]   w_prev_sample_next;
    logic                w_prev_valid_next;
    logic                w_trig_next;
    logic                w_frame_ready_next;
    logic                w_triggered_next;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic                w_trig_hit;
    logic                w_timeout_hit;
    logic                w_vblnk_rise;

    assign w_trig_hit = r_prev_valid && (bus.trig_slope
        ? (r_prev_sample > bus.trig_level && bus.sample_data <= bus.trig_level)
        : (r_prev_sample < bus.trig_level && bus.sample_data >= bus.trig_level));
    assign w_timeout_hit = (bus.trig_mode == MODE_AUTO) && (r_timeout == TO_LAST);
    assign w_vblnk_rise  = bus.vblnk & ~r_vblnk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_bank_sel    <= 1'b0;
            r_wr_addr     <= '0;
            r_timeout     <= '0;
            r_prev_sample <= '0;
            r_prev_valid  <= 1'b0;
            r_trig        <= 1'b0;
            r_vblnk_q     <= 1'b0;
            r_frame_ready <= 1'b0;
            r_triggered   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_bank_sel    <= w_bank_sel_next;
            r_wr_addr     <= w_wr_addr_next;
            r_timeout     <= w_timeout_next;
            r_prev_sample <= w_prev_sample_next;
            r_prev_valid  <= w_prev_valid_next;
            r_trig        <= w_trig_next;
            r_vblnk_q     <= bus.vblnk;
            r_frame_ready <= w_frame_ready_next;
            r_triggered   <= w_triggered_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_bank_sel_next    = r_bank_sel;
        w_wr_addr_next     = r_wr_addr;
        w_timeout_next     = r_timeout;
        w_prev_sample_next = r_prev_sample;
        w_prev_valid_next  = r_prev_valid;
        w_trig_next        = r_trig;
        w_frame_ready_next = 1'b0;
        w_triggered_next   = r_triggered;
        w_mem_we           = 1'b0;
        w_mem_addr         = r_wr_addr;
        case (r_state)
            S_IDLE: begin
                if (bus.trig_mode != MODE_SINGLE || bus.arm)
                    w_state_next = S_ARMED;
            end
            S_ARMED: begin
                if (bus.sample_valid) begin
                    w_prev_sample_next = bus.sample_data;
                    w_prev_valid_next  = 1'b1;
                    w_timeout_next     = r_timeout + TO_W'(1);
                    // A real trigger wins over a coincident auto timeout.
                    if (w_trig_hit || w_timeout_hit) begin
                        w_mem_we          = 1'b1;
                        w_mem_addr        = '0;
                        w_wr_addr_next    = ADDR_W'(1);
                        w_trig_next       = w_trig_hit;
                        w_timeout_next    = '0;
                        w_prev_valid_next = 1'b0;
                        w_state_next      = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (bus.sample_valid) begin
                    w_mem_we       = 1'b1;
                    w_mem_addr     = r_wr_addr;
                    w_wr_addr_next = r_wr_addr + ADDR_W'(1);
                    if (&r_wr_addr)
                        w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_vblnk_rise) begin
                    w_bank_sel_next    = ~r_bank_sel;
                    w_triggered_next   = r_trig;
                    w_frame_ready_next = 1'b1;
                    w_state_next       = (bus.trig_mode == MODE_SINGLE) ? S_IDLE : S_ARMED;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bank select is the address MSB; the capture side always writes the back bank.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst)
            r_mem[{~r_bank_sel, w_mem_addr}] <= bus.sample_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rd_data <= '0;
        else
            r_rd_data <= r_mem[{r_bank_sel, bus.rd_addr}];
    end

    assign bus.rd_data     = r_rd_data;
    assign bus.state       = r_state;
    assign bus.frame_ready = r_frame_ready;
    assign bus.triggered   = r_triggered;
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl: table-driven capture scenarios plus
// hand-written single-shot, held-vblank, mid-capture reset and gapped-stream sequences.
module tb_trace_capture_ctrl;
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ARMED   = 2'b01;
    localparam logic [1:0] ST_CAPTURE = 2'b10;
    localparam logic [1:0] ST_DONE    = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [11:0] sb [$];

    trace_capture_if #(.DATA_W(12), .ADDR_W(8)) bus ();

    trace_capture_ctrl #(.DATA_W(12), .ADDR_W(8), .AUTO_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       slope;
        int         level;
        int         start;
        int         step;
        int         exp_k0;
        logic       exp_trig;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ramp(input int start, input int step, input int k);
        return 12'((start + k * step) & 32'hFFF);
    endfunction

    // Streams ramp samples (one valid every 'gap' cycles) until DONE or max_valid samples.
    task automatic stream(input int start, input int step, input int gap, input int max_valid,
                          output int nvalid, output bit reached);
        nvalid  = 0;
        reached = 1'b0;
        for (int c = 0; c < 20000 && !reached && nvalid < max_valid; c++) begin
            if (c % gap == 0) begin
                bus.sample_valid = 1'b1;
                bus.sample_data  = ramp(start, step, nvalid);
                nvalid++;
            end else begin
                bus.sample_valid = 1'b0;
                bus.sample_data  = 12'hFFF;
            end
            tick();
            if (bus.state == ST_DONE) reached = 1'b1;
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic do_swap(input string name, input logic exp_trig, input logic [1:0] exp_state);
        bus.vblnk = 1'b1;
        tick();
        chk({name, "_frame_ready_hi"}, 32'(bus.frame_ready), 32'd1);
        chk({name, "_triggered"}, 32'(bus.triggered), 32'(exp_trig));
        chk({name, "_state_after_swap"}, 32'(bus.state), 32'(exp_state));
        tick();
        chk({name, "_frame_ready_lo"}, 32'(bus.frame_ready), 32'd0);
        bus.vblnk = 1'b0;
        tick();
    endtask

    task automatic read_frame(input string name, input int start, input int step, input int k0);
        logic [11:0] exp;
        for (int a = 0; a < 256; a++) begin
            bus.rd_addr = 8'(a);
            sb.push_back(ramp(start, step, k0 + a));
            tick();
            exp = sb.pop_front();
            chk($sformatf("%s_rd[%0d]", name, a), 32'(bus.rd_data), 32'(exp));
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_state"}, 32'(bus.state), 32'(ST_IDLE));
        chk({name, "_rd_data"}, 32'(bus.rd_data), 32'd0);
        chk({name, "_frame_ready"}, 32'(bus.frame_ready), 32'd0);
        chk({name, "_triggered"}, 32'(bus.triggered), 32'd0);
    endtask

    initial begin
        int n;
        bit reached;

        vecs[0] = '{2'b01, 1'b0, 'h800, 'h000, 16,     128, 1'b1};
        vecs[1] = '{2'b00, 1'b1, 'h800, 'h100, 0,      15,  1'b0};
        vecs[2] = '{2'b11, 1'b1, 'h800, 'hFFF, 'hFF0,  128, 1'b1};
        vecs[3] = '{2'b00, 1'b0, 'h400, 'h310, 16,     15,  1'b1};
        vecs[4] = '{2'b00, 1'b0, 'h100, 'h0C0, 16,     4,   1'b1};

        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.trig_level   = 12'h800;
        bus.trig_slope   = 1'b0;
        bus.trig_mode    = 2'b01;
        bus.arm          = 1'b0;
        bus.vblnk        = 1'b0;
        bus.rd_addr      = '0;

        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        chk("idle_to_armed", 32'(bus.state), 32'(ST_ARMED));

        for (int i = 0; i < 5; i++) begin
            bus.trig_mode  = vecs[i].mode;
            bus.trig_slope = vecs[i].slope;
            bus.trig_level = 12'(vecs[i].level);
            stream(vecs[i].start, vecs[i].step, 1, 5000, n, reached);
            chk($sformatf("vec%0d_done", i), 32'(reached), 32'd1);
            chk($sformatf("vec%0d_samples", i), 32'(n), 32'(vecs[i].exp_k0 + 256));
            do_swap($sformatf("vec%0d", i), vecs[i].exp_trig, ST_ARMED);
            read_frame($sformatf("vec%0d", i), vecs[i].start, vecs[i].step, vecs[i].exp_k0);
            $display("capture vec%0d mode=%0d slope=%0d samples=%0d triggered=%0d", i,
                     vecs[i].mode, vecs[i].slope, n, bus.triggered);
        end

        // Single shot: no capture without arm, exactly one after it.
        bus.trig_mode  = 2'b10;
        bus.trig_slope = 1'b0;
        bus.trig_level = 12'h800;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("single_idle", 32'(bus.state), 32'(ST_IDLE));
        stream(0, 16, 1, 1000, n, reached);
        chk("single_no_arm_done", 32'(reached), 32'd0);
        chk("single_no_arm_state", 32'(bus.state), 32'(ST_IDLE));
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("single_armed", 32'(bus.state), 32'(ST_ARMED));
        stream(0, 16, 1, 5000, n, reached);
        chk("single_done", 32'(reached), 32'd1);
        chk("single_samples", 32'(n), 32'd384);
        do_swap("single", 1'b1, ST_IDLE);
        read_frame("single", 0, 16, 128);
        stream(0, 16, 1, 600, n, reached);
        chk("single_second_done", 32'(reached), 32'd0);
        chk("single_second_state", 32'(bus.state), 32'(ST_IDLE));
        bus.vblnk = 1'b1;
        tick();
        chk("single_no_second_swap", 32'(bus.frame_ready), 32'd0);
        bus.vblnk = 1'b0;
        bus.rd_addr = 8'd0;
        sb.push_back(12'h800);
        tick();
        chk("single_front_kept", 32'(bus.rd_data), 32'(sb.pop_front()));
        $display("capture single samples=%0d state=%0d", n, bus.state);

        // vblnk already high when DONE is entered.
        bus.trig_mode = 2'b01;
        bus.vblnk     = 1'b1;
        tick();
        chk("vhold_armed", 32'(bus.state), 32'(ST_ARMED));
        stream('h705, 8, 1, 5000, n, reached);
        chk("vhold_done", 32'(reached), 32'd1);
        chk("vhold_samples", 32'(n), 32'd288);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("vhold_no_swap%0d", c), 32'(bus.frame_ready), 32'd0);
            chk($sformatf("vhold_state%0d", c), 32'(bus.state), 32'(ST_DONE));
        end
        bus.rd_addr = 8'd0;
        sb.push_back(12'h800);
        tick();
        chk("vhold_old_front", 32'(bus.rd_data), 32'(sb.pop_front()));
        bus.vblnk = 1'b0;
        tick();
        do_swap("vhold", 1'b1, ST_ARMED);
        read_frame("vhold", 'h705, 8, 32);
        $display("capture vblank_held samples=%0d", n);

        // Reset with wr_addr = 100 aborts the capture.
        stream('h7FB, 5, 1, 101, n, reached);
        chk("rst_mid_not_done", 32'(reached), 32'd0);
        chk("rst_mid_capturing", 32'(bus.state), 32'(ST_CAPTURE));
        rst = 1'b1;
        tick();
        chk_reset("rst_mid");
        rst = 1'b0;
        tick();
        chk("rst_mid_rearmed", 32'(bus.state), 32'(ST_ARMED));
        stream('h7F0, 1, 1, 5000, n, reached);
        chk("post_rst_done", 32'(reached), 32'd1);
        chk("post_rst_samples", 32'(n), 32'd272);
        do_swap("post_rst", 1'b1, ST_ARMED);
        read_frame("post_rst", 'h7F0, 1, 16);
        $display("capture post_reset samples=%0d", n);

        // One valid sample every third cycle.
        stream('h020, 16, 3, 5000, n, reached);
        chk("gap_done", 32'(reached), 32'd1);
        chk("gap_samples", 32'(n), 32'd382);
        do_swap("gap", 1'b1, ST_ARMED);
        read_frame("gap", 'h020, 16, 126);
        $display("capture gapped samples=%0d", n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
